// File: rtl/matrix_frame_sender.sv
// matrix_frame_sender: serializes an NLEDS-bit frame onto din/dclk, MSB first,
// then pulses strobe so the LED matrix driver latches the frame.
// All outputs are registered and every timed phase lasts CLK_DIV clk cycles.
// Optional macro FRAME_DBUF_EN: adds a one-deep pending frame so that a start
// seen while busy is queued and sent back-to-back with no idle gap.
module matrix_frame_sender #(
  parameter int NLEDS   = 64,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NLEDS-1:0] frame,
  input  logic             start,
  output logic             din,
  output logic             dclk,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int IW = (NLEDS > 1) ? $clog2(NLEDS) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NLEDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_LO  = 3'd1,
    SHIFT_HI  = 3'd2,
    GAP       = 3'd3,
    STROBE_HI = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    phase_r;
  logic [IW-1:0]    idx_r;
  logic [NLEDS-1:0] shadow_r;
  logic             din_r;
  logic             dclk_r;
  logic             strobe_r;
  logic             busy_r;
  logic             done_r;
  logic             phase_last_s;

  assign phase_last_s = (phase_r == PH_LAST);

  assign din    = din_r;
  assign dclk   = dclk_r;
  assign strobe = strobe_r;
  assign busy   = busy_r;
  assign done   = done_r;

`ifdef FRAME_DBUF_EN
  logic [NLEDS-1:0] pend_r;
  logic             pend_flag_r;
  logic [NLEDS-1:0] next_frame_s;

  // A start arriving in the DONE cycle itself is used directly as the next frame.
  assign next_frame_s = start ? frame : pend_r;

  // Pending frame capture: last start while busy wins; consumed in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r      <= {NLEDS{1'b0}};
      pend_flag_r <= 1'b0;
    end else if (state_r == DONE) begin
      pend_flag_r <= 1'b0;
    end else if (start && (state_r != IDLE)) begin
      pend_r      <= frame;
      pend_flag_r <= 1'b1;
    end else begin
      pend_r      <= pend_r;
      pend_flag_r <= pend_flag_r;
    end
  end
`endif

  // Transfer sequencer: state, phase/bit counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      phase_r  <= {PW{1'b0}};
      idx_r    <= {IW{1'b0}};
      shadow_r <= {NLEDS{1'b0}};
      din_r    <= 1'b0;
      dclk_r   <= 1'b0;
      strobe_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r   <= 1'b0;
          strobe_r <= 1'b0;
          dclk_r   <= 1'b0;
          phase_r  <= {PW{1'b0}};
          if (start) begin
            shadow_r <= frame;
            idx_r    <= IDX_TOP;
            din_r    <= frame[NLEDS-1];
            busy_r   <= 1'b1;
            state_r  <= SHIFT_LO;
          end else begin
            din_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end

        SHIFT_LO: begin
          if (phase_last_s) begin
            phase_r <= {PW{1'b0}};
            dclk_r  <= 1'b1;
            state_r <= SHIFT_HI;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        SHIFT_HI: begin
          if (phase_last_s) begin
            phase_r <= {PW{1'b0}};
            dclk_r  <= 1'b0;
            if (idx_r == {IW{1'b0}}) begin
              din_r   <= 1'b0;
              state_r <= GAP;
            end else begin
              // din only moves here, together with the falling dclk edge
              idx_r   <= idx_r - IW'(1);
              din_r   <= shadow_r[idx_r - IW'(1)];
              state_r <= SHIFT_LO;
            end
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        GAP: begin
          if (phase_last_s) begin
            phase_r  <= {PW{1'b0}};
            strobe_r <= 1'b1;
            state_r  <= STROBE_HI;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        STROBE_HI: begin
          if (phase_last_s) begin
            phase_r  <= {PW{1'b0}};
            strobe_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end

        DONE: begin
          done_r  <= 1'b0;
          phase_r <= {PW{1'b0}};
`ifdef FRAME_DBUF_EN
          if (start || pend_flag_r) begin
            shadow_r <= next_frame_s;
            idx_r    <= IDX_TOP;
            din_r    <= next_frame_s[NLEDS-1];
            busy_r   <= 1'b1;
            state_r  <= SHIFT_LO;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
`else
          busy_r  <= 1'b0;
          state_r <= IDLE;
`endif
        end

        default: begin
          state_r  <= IDLE;
          phase_r  <= {PW{1'b0}};
          din_r    <= 1'b0;
          dclk_r   <= 1'b0;
          strobe_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_sender.sv
// Scoreboard bench for matrix_frame_sender: a cycle-level reference model
// predicts every output from the transfer timeline, a driver model (shift
// chain + latch) receives the serial stream, and a monitor checks vbuf
// against the queued expected frames on each done pulse.
module tb_matrix_frame_sender;

  localparam int N = 64;
`ifdef FRAME_DBUF_EN
  localparam int CD = 1;
`else
  localparam int CD = 4;
`endif
  localparam int BUSY = 2*CD*N + 2*CD + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] frame = '0;
  logic         din, dclk, strobe, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_frame_sender #(.NLEDS(N), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .frame(frame), .start(start),
    .din(din), .dclk(dclk), .strobe(strobe), .busy(busy), .done(done)
  );

  // ---------------- reference model (transfer timeline) ----------------
  int           cnt = 0;       // busy cycles remaining, 0 = idle
  logic [N-1:0] cur = '0;
  logic [N-1:0] pend = '0;
  bit           pflag = 0;
  logic [N-1:0] exp_q[$];
  bit           chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      cnt = 0; pflag = 0; exp_q.delete(); chk_en = 1;
    end else if (cnt == 0) begin
      if (start) begin cur = frame; exp_q.push_back(frame); cnt = BUSY; end
    end else begin
`ifdef FRAME_DBUF_EN
      if (start) begin pend = frame; pflag = 1; end
`endif
      if (cnt == 1 && pflag) begin
        cur = pend; exp_q.push_back(pend); pflag = 0; cnt = BUSY;
      end else begin
        cnt--;
      end
    end
  end

  // {busy, done, strobe, dclk, din} expected in the current cycle
  function automatic logic [4:0] expect_outs();
    int k;
    logic [4:0] e;
    e = 5'b0;
    if (cnt == 0) return e;
    k = BUSY - cnt;
    e[4] = 1'b1;
    if (k < 2*CD*N) begin
      e[1] = ((k / CD) % 2) == 1;
      e[0] = cur[N-1 - k/(2*CD)];
    end else if (k >= 2*CD*N + CD && k < 2*CD*N + 2*CD) begin
      e[2] = 1'b1;
    end else if (k == BUSY - 1) begin
      e[3] = 1'b1;
    end
    return e;
  endfunction

  // ---------------- driver model: shift chain and latch ----------------
  logic [N-1:0] chain = '0, vbuf = '0;
  logic         dclk_p = 1'b0, strobe_p = 1'b0;
  int           d_rises = 0, s_rises = 0;

  always @(posedge clk) begin
    dclk_p   <= dclk;
    strobe_p <= strobe;
    if (dclk === 1'b1 && dclk_p === 1'b0) begin
      chain   <= {chain[N-2:0], din};
      d_rises <= d_rises + 1;
    end
    if (strobe === 1'b1 && strobe_p === 1'b0) begin
      vbuf    <= chain;
      s_rises <= s_rises + 1;
    end
  end

  // ---------------- monitor ----------------
  int d_base = 0, s_base = 0;

  always @(negedge clk) begin
    logic [4:0] ex, ac;
    logic [N-1:0] ef;
    if (chk_en) begin
      ex = expect_outs();
      ac = {busy, done, strobe, dclk, din};
      n_vec++;
      if (ac !== ex) begin
        n_err++;
        $display("FAIL outs t=%0t {busy,done,strobe,dclk,din} got=%b expected=%b", $time, ac, ex);
      end
      if (done === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected t=%0t got done=1 expected no transfer", $time);
        end else begin
          ef = exp_q.pop_front();
          if (vbuf !== ef) begin
            n_err++;
            $display("FAIL vbuf t=%0t got=%h expected=%h", $time, vbuf, ef);
          end
        end
        n_vec++;
        if (d_rises - d_base != N || s_rises - s_base != 1) begin
          n_err++;
          $display("FAIL edge_count t=%0t got dclk=%0d strobe=%0d expected dclk=%0d strobe=1",
                   $time, d_rises - d_base, s_rises - s_base, N);
        end
        d_base = d_rises;
        s_base = s_rises;
      end
      if (reset) begin
        d_base = d_rises;
        s_base = s_rises;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [N-1:0] rnd_frame();
    return {$urandom, $urandom};
  endfunction

  task automatic pulse_start(input logic [N-1:0] f);
    @(negedge clk);
    frame = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame = rnd_frame();   // frame changes mid-transfer must not matter
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 4*BUSY && !ok; i++) begin
      @(negedge clk);
      if (cnt == 0 && busy === 1'b0) ok = 1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL idle_timeout t=%0t got busy=%b expected 0", $time, busy);
    end
  endtask

  initial begin
    int r0;
    bit hit;
    logic [N-1:0] fa, fb;

    // reset held with start asserted, then quiet period
    reset = 1'b1; start = 1'b1; frame = rnd_frame();
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (d_rises != 0) begin
      n_err++;
      $display("FAIL quiet_after_reset got dclk rises=%0d expected 0", d_rises);
    end

    pulse_start(64'h8000_0000_0000_0001);
    wait_idle();
    pulse_start(64'hDEAD_BEEF_0123_4567);
    wait_idle();

    // second start while busy: ignored, or queued with the pending buffer
    fa = rnd_frame();
    fb = ~fa;
    pulse_start(fa);
    repeat (((CD == 1) ? 10 : 100) - 2) @(negedge clk);
    pulse_start(fb);
    wait_idle();

    // reset after the 30th dclk rise, then a clean transfer
    r0 = d_rises;
    pulse_start(rnd_frame());
    hit = 0;
    for (int i = 0; i < 4*BUSY && !hit; i++) begin
      @(negedge clk);
      if (d_rises - r0 >= 30) hit = 1;
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL rise30_timeout got rises=%0d expected 30", d_rises - r0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start(rnd_frame());
    wait_idle();

    // randomized frames, gaps and extra starts during busy
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_start(rnd_frame());
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, BUSY - 3)) @(negedge clk);
        pulse_start(rnd_frame());
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL undelivered got %0d frames left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_frame_sender.md
Name: matrix_frame_sender

Overview:
- Host-side serializer for the LED matrix driver's load interface.
- Captures an NLEDS-bit frame and shifts it out on din/dclk, most significant bit first.
- Pulses strobe once after the last bit so the driver latches the frame into its display buffer.
- Runs entirely in the clk domain; dclk and strobe are registered, divided-down outputs.

Parameters:
- NLEDS, 64, frame width in bits; must equal the driver's chain length.
- CLK_DIV, 4, clk cycles per dclk phase (low or high) and per strobe phase; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame  input  NLEDS  frame data; bit NLEDS-1 = chain[NLEDS-1] on the driver
- start  input  1  request to send frame; sampled every clk edge
- din  output  1  serial data to driver
- dclk  output  1  data clock to driver
- strobe  output  1  latch pulse to driver
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset state:
  - din=0, dclk=0, strobe=0, busy=0, done=0.
  - State IDLE; bit counter, phase counter and shadow register cleared.
  - Reset mid-transfer aborts on the next edge; no strobe is issued.
- States: IDLE, SHIFT_LO, SHIFT_HI, GAP, STROBE_HI, DONE.
- IDLE:
  - If start=1 at edge T0, latch frame into a shadow register, load bit index NLEDS-1 and go to SHIFT_LO.
  - busy=1 from edge T0+1 onward.
- SHIFT_LO:
  - din = shadow[index]; dclk=0 for CLK_DIV cycles.
  - din changes only on entry to SHIFT_LO, never while dclk=1.
- SHIFT_HI:
  - dclk=1 for CLK_DIV cycles; din is held.
  - On exit with index=0, go to GAP. Otherwise decrement index and go to SHIFT_LO.
- GAP: dclk=0, din=0 for CLK_DIV cycles, giving setup before strobe.
- STROBE_HI: strobe=1 for CLK_DIV cycles.
- DONE:
  - strobe=0 and done=1 for exactly one cycle; busy still 1 during this cycle.
  - Next state is IDLE with busy=0.
- Order and counts:
  - First bit sent is frame[NLEDS-1], last is frame[0]. After strobe, the driver holds vbuf == frame.
  - Exactly NLEDS dclk rising edges and exactly one strobe rising edge per transfer.
  - strobe never overlaps dclk=1.
- Latency: busy is high for 2*CLK_DIV*NLEDS + 2*CLK_DIV + 1 cycles (521 at defaults).
- Phase counter: width $clog2(CLK_DIV+1); it reloads to 0 on every state change.
- Bit index: width $clog2(NLEDS); it does not wrap, because the transition on index=0 is explicit.
- frame is only sampled on an accepted start; changes to frame during a transfer have no effect.
- start while busy (macro off): ignored, not queued.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: FRAME_DBUF_EN.
- Defined:
  - Adds a pending register and pending flag.
  - start while busy latches frame into pending and sets the flag; a later start overwrites pending (last-writer-wins).
  - On the DONE cycle, if the flag is set: pending moves to shadow, the flag clears, and the next state is SHIFT_LO. busy stays 1 with no idle gap; done still pulses.
  - start in the DONE cycle itself is treated as queued.
  - reset clears pending and the flag.
- Undefined:
  - No pending storage.
  - start while busy is ignored as above.

Test Plan:
- Reset: hold reset 3 cycles with start=1 -> din, dclk, strobe, busy, done all 0, and no dclk edges for 20 cycles after release with start=0.
- Single frame, defaults, frame=64'h8000_0000_0000_0001, start pulsed 1 cycle:
  - Exactly 64 dclk rises; din=1 on rise 1 and rise 64, 0 otherwise.
  - One strobe pulse of 4 cycles, then done one cycle.
  - busy high for 521 cycles.
- Loopback: connect to a behavioural model of the driver's shift chain and latch; send 64'hDEAD_BEEF_0123_4567 -> model vbuf equals frame after strobe.
- Busy rejection, macro off: start again at busy cycle 100 with a different frame -> only the first frame is delivered; busy drops after 521 cycles; one done.
- Reset mid-transfer: assert reset after dclk rise 30 -> all outputs 0 next cycle; no strobe. A new start then delivers a full 64-bit frame correctly.
- Queued frames, FRAME_DBUF_EN defined, CLK_DIV=1: start frame A, then start frame B at busy cycle 10:
  - busy high continuously for 2*(2*64+2+1)=262 cycles.
  - Two done pulses; model vbuf = A after the first strobe and B after the second.
